// File: rtl/pic_pkg.sv
// Shared types and command encodings for the 8259A-style control logic.
// Init FSM states, ICW1 flag position, OCW select values and OCW2 command codes.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_ICW1,
    ST_WAIT_ICW2,
    ST_WAIT_ICW3,
    ST_WAIT_ICW4,
    ST_READY
  } init_state_t;

  localparam int          ICW1_FLAG_BIT = 4;
  localparam logic [1:0]  OCW_SEL_OCW2  = 2'b00;
  localparam logic [1:0]  OCW_SEL_OCW3  = 2'b01;

  // OCW2 command field (din[7:5]) and rotate field (din[7:6]).
  typedef enum logic [2:0] {
    OCW2_NS_EOI   = 3'b001,
    OCW2_SPEC_EOI = 3'b011
  } ocw2_eoi_t;

  typedef enum logic [1:0] {
    OCW2_ROT_NS   = 2'b10,
    OCW2_ROT_SPEC = 2'b11
  } ocw2_rot_t;

endpackage

// File: rtl/inta_sequencer.sv
// INTA falling-edge detector: issues first/second ack strobes and latches the vector.
// Latency: acks one cycle after inta_n sampled low; vector valid one cycle after second_ack.
module inta_sequencer #(
  parameter int VEC_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_abort,
  input  logic             i_enable,
  input  logic             i_inta_n,
  input  logic [VEC_W-4:0] i_vec_base,
  input  logic [2:0]       i_int_vec,
  output logic             o_first_ack,
  output logic             o_second_ack,
  output logic [VEC_W-1:0] o_vec_out,
  output logic             o_vec_oe
);

  logic             r_inta_q;
  logic [1:0]       r_ack_cnt;
  logic             r_vec_pending;
  logic             r_first_ack;
  logic             r_second_ack;
  logic [VEC_W-1:0] r_vec_out;
  logic             r_vec_oe;
  logic             w_fall;

  assign w_fall = r_inta_q & ~i_inta_n;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_inta_q      <= 1'b1;
      r_ack_cnt     <= 2'd0;
      r_vec_pending <= 1'b0;
      r_first_ack   <= 1'b0;
      r_second_ack  <= 1'b0;
      r_vec_out     <= '0;
      r_vec_oe      <= 1'b0;
    end else begin
      r_inta_q      <= i_inta_n;
      r_first_ack   <= 1'b0;
      r_second_ack  <= 1'b0;
      r_vec_pending <= 1'b0;
      // Abort beats a coincident edge: no strobe, counter restarts from the first ack.
      if (i_abort) begin
        r_ack_cnt <= 2'd0;
        r_vec_oe  <= 1'b0;
      end else begin
        if (w_fall && i_enable) begin
          case (r_ack_cnt)
            2'd0: begin
              r_first_ack <= 1'b1;
              r_ack_cnt   <= 2'd1;
            end
            2'd1: begin
              r_second_ack  <= 1'b1;
              r_ack_cnt     <= 2'd0;
              r_vec_pending <= 1'b1;
            end
            default: r_ack_cnt <= 2'd0;
          endcase
        end
        if (r_vec_pending) begin
          r_vec_out <= {i_vec_base, i_int_vec};
          r_vec_oe  <= 1'b1;
        end else if (i_inta_n) begin
          r_vec_oe <= 1'b0;
        end
      end
    end
  end

  assign o_first_ack  = r_first_ack;
  assign o_second_ack = r_second_ack;
  assign o_vec_out    = r_vec_out;
  assign o_vec_oe     = r_vec_oe;

endmodule

// File: rtl/pic_control_logic.sv
// ICW/OCW command sequencer and INTA acknowledge controller for the priority resolver.
// Writes take effect at the sampling edge; INT to the CPU is gated until READY.
module pic_control_logic
  import pic_pkg::*;
#(
  parameter int VEC_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr,
  input  logic             i_a0,
  input  logic [VEC_W-1:0] i_din,
  input  logic             i_inta_n,
  input  logic             i_int_req,
  input  logic [2:0]       i_int_vec,
  output logic             o_int_out,
  output logic             o_ltim,
  output logic [VEC_W-1:0] o_im,
  output logic [VEC_W-1:0] o_operation,
  output logic             o_op_strobe,
  output logic             o_aeoi,
  output logic             o_sngl,
  output logic             o_read_isr,
  output logic             o_first_ack,
  output logic             o_second_ack,
  output logic [VEC_W-1:0] o_vec_out,
  output logic             o_vec_oe,
  output logic             o_init_done
);

  init_state_t      r_state;
  init_state_t      w_state_nxt;
  logic             w_init_done;
  logic             w_icw1;
  logic             w_data_wr;
  logic             w_cmd_wr;
  logic [1:0]       w_ocw_sel;

  logic             r_ltim;
  logic             r_sngl;
  logic             r_ic4;
  logic             r_aeoi;
  logic             r_read_isr;
  logic             r_op_strobe;
  logic [VEC_W-1:0] r_im;
  logic [VEC_W-1:0] r_operation;
  logic [VEC_W-1:0] r_icw3;
  logic [VEC_W-4:0] r_vec_base;
  logic             w_unused_icw3;

  assign w_icw1    = i_wr & ~i_a0 & i_din[ICW1_FLAG_BIT];
  assign w_data_wr = i_wr & i_a0;
  assign w_cmd_wr  = i_wr & ~i_a0 & ~i_din[ICW1_FLAG_BIT];
  assign w_ocw_sel = i_din[4:3];

  // Slave-ID byte is captured for completeness; cascade addressing is handled elsewhere.
  assign w_unused_icw3 = ^r_icw3;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_WAIT_ICW1;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_icw1) begin
      w_state_nxt = ST_WAIT_ICW2;
    end else if (w_data_wr) begin
      case (r_state)
        ST_WAIT_ICW2: w_state_nxt = !r_sngl ? ST_WAIT_ICW3 : (r_ic4 ? ST_WAIT_ICW4 : ST_READY);
        ST_WAIT_ICW3: w_state_nxt = r_ic4 ? ST_WAIT_ICW4 : ST_READY;
        ST_WAIT_ICW4: w_state_nxt = ST_READY;
        default:      w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_init_done = (r_state == ST_READY);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ltim      <= 1'b0;
      r_sngl      <= 1'b1;
      r_ic4       <= 1'b0;
      r_aeoi      <= 1'b0;
      r_read_isr  <= 1'b0;
      r_op_strobe <= 1'b0;
      r_im        <= '1;
      r_operation <= '0;
      r_icw3      <= '0;
      r_vec_base  <= '0;
    end else begin
      r_op_strobe <= 1'b0;
      if (w_icw1) begin
        r_ltim      <= i_din[3];
        r_sngl      <= i_din[1];
        r_ic4       <= i_din[0];
        r_im        <= '0;
        r_operation <= '0;
        r_aeoi      <= 1'b0;
        r_read_isr  <= 1'b0;
      end else begin
        case (r_state)
          ST_WAIT_ICW2: if (w_data_wr) r_vec_base <= i_din[VEC_W-1:3];
          ST_WAIT_ICW3: if (w_data_wr) r_icw3 <= i_din;
          ST_WAIT_ICW4: if (w_data_wr) r_aeoi <= i_din[1];
          ST_READY: begin
            if (w_data_wr) begin
              r_im <= i_din;
            end else if (w_cmd_wr && w_ocw_sel == OCW_SEL_OCW2) begin
              r_operation <= i_din;
              r_op_strobe <= 1'b1;
            end else if (w_cmd_wr && w_ocw_sel == OCW_SEL_OCW3 && i_din[1]) begin
              r_read_isr <= i_din[0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  inta_sequencer #(
    .VEC_W (VEC_W)
  ) u_inta_sequencer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_abort      (w_icw1),
    .i_enable     (w_init_done),
    .i_inta_n     (i_inta_n),
    .i_vec_base   (r_vec_base),
    .i_int_vec    (i_int_vec),
    .o_first_ack  (o_first_ack),
    .o_second_ack (o_second_ack),
    .o_vec_out    (o_vec_out),
    .o_vec_oe     (o_vec_oe)
  );

  assign o_int_out   = i_int_req & w_init_done;
  assign o_init_done = w_init_done;
  assign o_ltim      = r_ltim;
  assign o_sngl      = r_sngl;
  assign o_aeoi      = r_aeoi;
  assign o_read_isr  = r_read_isr;
  assign o_im        = r_im;
  assign o_operation = r_operation;
  assign o_op_strobe = r_op_strobe;

endmodule

// File: tb/tb_pic_control_logic.sv
// Directed bench for pic_control_logic: per-cycle vector table plus reset/INTA corner sequences.
module tb_pic_control_logic;

  logic       clk = 1'b0;
  logic       reset, wr, a0, inta_n, int_req;
  logic [7:0] din;
  logic [2:0] int_vec;
  logic       int_out, ltim, op_strobe, aeoi, sngl, read_isr;
  logic       first_ack, second_ack, vec_oe, init_done;
  logic [7:0] im, operation, vec_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pic_control_logic #(.VEC_W(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_wr(wr), .i_a0(a0), .i_din(din),
    .i_inta_n(inta_n), .i_int_req(int_req), .i_int_vec(int_vec),
    .o_int_out(int_out), .o_ltim(ltim), .o_im(im), .o_operation(operation),
    .o_op_strobe(op_strobe), .o_aeoi(aeoi), .o_sngl(sngl), .o_read_isr(read_isr),
    .o_first_ack(first_ack), .o_second_ack(second_ack), .o_vec_out(vec_out),
    .o_vec_oe(vec_oe), .o_init_done(init_done)
  );

  typedef struct packed {
    logic       done, int_out, ltim, sngl, aeoi, risr, ops, fa, sa, oe;
    logic [7:0] im, op, vec;
  } out_t;

  typedef struct {
    string      name;
    logic       rst, wr, a0;
    logic [7:0] din;
    logic       inta_n, int_req;
    out_t       exp;
  } vec_t;

  vec_t vq[$];

  function automatic out_t E(input logic done, iout, lt, sg, ae, ri, ops, fa, sa, oe,
                             input logic [7:0] im_e, op_e, vec_e);
    out_t o;
    o = '{done, iout, lt, sg, ae, ri, ops, fa, sa, oe, im_e, op_e, vec_e};
    return o;
  endfunction

  function automatic out_t cur();
    out_t o;
    o = '{init_done, int_out, ltim, sngl, aeoi, read_isr, op_strobe, first_ack,
          second_ack, vec_oe, im, operation, vec_out};
    return o;
  endfunction

  task automatic add(input string nm, input logic r, w, a, input logic [7:0] d,
                     input logic ia, ir, input out_t ex);
    vec_t v;
    v.name = nm; v.rst = r; v.wr = w; v.a0 = a; v.din = d;
    v.inta_n = ia; v.int_req = ir; v.exp = ex;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cycle(input logic a, input logic [7:0] d);
    wr = 1'b1; a0 = a; din = d;
    tick();
    wr = 1'b0; a0 = 1'b0; din = 8'h00;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    out_t R;
    int   waited;
    R = E(0,0,0,1,0,0,0,0,0,0,8'hFF,8'h00,8'h00);

    //   name                   rst wr a0 din    inta ireq  expected
    add("reset_int_gated",      1, 0, 0, 8'h00, 1, 1, R);
    add("idle_int_gated",       0, 0, 0, 8'h00, 1, 1, R);
    add("a0_before_icw1",       0, 1, 1, 8'h55, 1, 1, R);
    add("icw1_13",              0, 1, 0, 8'h13, 1, 1, E(0,0,0,1,0,0,0,0,0,0,8'h00,8'h00,8'h00));
    add("cmd_ignored_wait",     0, 1, 0, 8'h02, 1, 1, E(0,0,0,1,0,0,0,0,0,0,8'h00,8'h00,8'h00));
    add("icw2_40_skip_icw3",    0, 1, 1, 8'h40, 1, 1, E(0,0,0,1,0,0,0,0,0,0,8'h00,8'h00,8'h00));
    add("icw4_02_ready",        0, 1, 1, 8'h02, 1, 1, E(1,1,0,1,1,0,0,0,0,0,8'h00,8'h00,8'h00));
    add("int_req_low",          0, 0, 0, 8'h00, 1, 0, E(1,0,0,1,1,0,0,0,0,0,8'h00,8'h00,8'h00));
    add("ocw1_f0",              0, 1, 1, 8'hF0, 1, 0, E(1,0,0,1,1,0,0,0,0,0,8'hF0,8'h00,8'h00));
    add("ocw2_20_strobe",       0, 1, 0, 8'h20, 1, 0, E(1,0,0,1,1,0,1,0,0,0,8'hF0,8'h20,8'h00));
    add("strobe_one_cycle",     0, 0, 0, 8'h00, 1, 0, E(1,0,0,1,1,0,0,0,0,0,8'hF0,8'h20,8'h00));
    add("ocw3_0b_isr",          0, 1, 0, 8'h0B, 1, 0, E(1,0,0,1,1,1,0,0,0,0,8'hF0,8'h20,8'h00));
    add("ocw3_08_no_rr",        0, 1, 0, 8'h08, 1, 0, E(1,0,0,1,1,1,0,0,0,0,8'hF0,8'h20,8'h00));
    add("inta1_fall",           0, 0, 0, 8'h00, 0, 0, E(1,0,0,1,1,1,0,1,0,0,8'hF0,8'h20,8'h00));
    add("inta1_stuck_low",      0, 0, 0, 8'h00, 0, 0, E(1,0,0,1,1,1,0,0,0,0,8'hF0,8'h20,8'h00));
    add("inta1_rise",           0, 0, 0, 8'h00, 1, 0, E(1,0,0,1,1,1,0,0,0,0,8'hF0,8'h20,8'h00));
    add("inta2_fall",           0, 0, 0, 8'h00, 0, 0, E(1,0,0,1,1,1,0,0,1,0,8'hF0,8'h20,8'h00));
    add("vec_valid_45",         0, 0, 0, 8'h00, 0, 0, E(1,0,0,1,1,1,0,0,0,1,8'hF0,8'h20,8'h45));
    add("vec_hold",             0, 0, 0, 8'h00, 0, 0, E(1,0,0,1,1,1,0,0,0,1,8'hF0,8'h20,8'h45));
    add("vec_release",          0, 0, 0, 8'h00, 1, 0, E(1,0,0,1,1,1,0,0,0,0,8'hF0,8'h20,8'h45));
    add("ocw1_with_inta_edge",  0, 1, 1, 8'h0F, 0, 0, E(1,0,0,1,1,1,0,1,0,0,8'h0F,8'h20,8'h45));
    add("inta_rise_a",          0, 0, 0, 8'h00, 1, 0, E(1,0,0,1,1,1,0,0,0,0,8'h0F,8'h20,8'h45));
    add("icw1_beats_inta",      0, 1, 0, 8'h1A, 0, 0, E(0,0,1,1,0,0,0,0,0,0,8'h00,8'h00,8'h45));
    add("inta_rise_b",          0, 0, 0, 8'h00, 1, 0, E(0,0,1,1,0,0,0,0,0,0,8'h00,8'h00,8'h45));
    add("icw2_no_icw4_ready",   0, 1, 1, 8'h40, 1, 0, E(1,0,1,1,0,0,0,0,0,0,8'h00,8'h00,8'h45));
    add("first_after_reinit",   0, 0, 0, 8'h00, 0, 0, E(1,0,1,1,0,0,0,1,0,0,8'h00,8'h00,8'h45));
    add("inta_rise_c",          0, 0, 0, 8'h00, 1, 0, E(1,0,1,1,0,0,0,0,0,0,8'h00,8'h00,8'h45));
    add("icw1_10_cascade",      0, 1, 0, 8'h10, 1, 0, E(0,0,0,0,0,0,0,0,0,0,8'h00,8'h00,8'h45));
    add("icw2_48_to_icw3",      0, 1, 1, 8'h48, 1, 0, E(0,0,0,0,0,0,0,0,0,0,8'h00,8'h00,8'h45));
    add("icw3_04_ready",        0, 1, 1, 8'h04, 1, 1, E(1,1,0,0,0,0,0,0,0,0,8'h00,8'h00,8'h45));
    add("icw1_10_again",        0, 1, 0, 8'h10, 1, 1, E(0,0,0,0,0,0,0,0,0,0,8'h00,8'h00,8'h45));
    add("icw2_40_again",        0, 1, 1, 8'h40, 1, 1, E(0,0,0,0,0,0,0,0,0,0,8'h00,8'h00,8'h45));
    add("reset_mid_init",       1, 0, 0, 8'h00, 1, 1, R);
    add("a0_after_reset",       0, 1, 1, 8'h11, 1, 1, R);

    int_vec = 3'd5;
    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; wr = vq[i].wr; a0 = vq[i].a0; din = vq[i].din;
      inta_n = vq[i].inta_n; int_req = vq[i].int_req;
      tick();
      chk(vq[i].name, 64'(cur()), 64'(vq[i].exp));
    end

    // Reset in the middle of an INTA pair must restart the ack counter.
    wr = 1'b0; a0 = 1'b0; din = 8'h00; inta_n = 1'b1; int_req = 1'b0; reset = 1'b0;
    wr_cycle(1'b0, 8'h13);
    wr_cycle(1'b1, 8'h40);
    wr_cycle(1'b1, 8'h02);
    chk("seq_init_done", 64'(init_done), 64'd1);
    inta_n = 1'b0; tick();
    chk("seq_first_ack", 64'(first_ack), 64'd1);
    inta_n = 1'b1; tick();
    reset = 1'b1; tick();
    chk("seq_reset_state", 64'(cur()), 64'(R));
    reset = 1'b0;
    wr_cycle(1'b0, 8'h13);
    wr_cycle(1'b1, 8'h40);
    wr_cycle(1'b1, 8'h02);
    inta_n = 1'b0; tick();
    chk("seq_acks_after_reset", 64'({first_ack, second_ack}), 64'(2'b10));
    inta_n = 1'b1; tick();

    // Second pulse with a new vector; vec_oe must appear two edges after the fall.
    int_vec = 3'd3;
    inta_n = 1'b0;
    waited = 0;
    while (!vec_oe && waited < 20) begin
      tick();
      waited++;
    end
    chk("seq_vec_oe_latency", 64'(waited), 64'd2);
    chk("seq_vec_out_43", 64'(vec_out), 64'h43);
    inta_n = 1'b1; tick();
    chk("seq_vec_oe_clear", 64'(vec_oe), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pic_control_logic.md
# pic_control_logic

Synchronous command sequencer and acknowledge controller for the 8259A-style priority resolver. It decodes CPU writes into the ICW1–ICW4 initialization sequence and the OCW1–OCW3 operation commands, and drives the resolver's configuration lines (`ltim`, `im`, `operation`, `aeoi`). It converts the CPU's INTA pulse pair into `first_ack`/`second_ack` strobes and drives the 8-bit interrupt vector onto the data path. It sits between the read/write logic and the priority resolver, and gates INT to the CPU until initialization completes.

## Interface
Parameters:
- `VEC_W`, default 8: vector/data bus width; fixed at 8 for 8259A compatibility.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr` in 1: one-cycle write strobe from the read/write logic.
- `a0` in 1: address bit 0 qualifying `wr`.
- `din` in 8: write data.
- `inta_n` in 1: CPU acknowledge, active-low, already synchronized to `clk`.
- `int_req` in 1: INT from the priority resolver.
- `int_vec` in 3: INT_VEC from the priority resolver.
- `int_out` out 1: INT to the CPU, equal to `int_req & init_done` (combinational).
- `ltim` out 1: level-triggered mode (ICW1 bit 3).
- `im` out 8: interrupt mask (OCW1).
- `operation` out 8: last OCW2 byte.
- `op_strobe` out 1: one-cycle pulse in the cycle `operation` is updated.
- `aeoi` out 1: auto-EOI (ICW4 bit 1).
- `sngl` out 1: single mode (ICW1 bit 1).
- `read_isr` out 1: status-read select (OCW3); 1 = ISR, 0 = IRR.
- `first_ack` out 1: one-cycle pulse on the first INTA falling edge.
- `second_ack` out 1: one-cycle pulse on the second INTA falling edge.
- `vec_out` out 8: `{vec_base[4:0], int_vec}`.
- `vec_oe` out 1: vector output enable.
- `init_done` out 1: high while in state READY.

## Operation
**Init FSM states:** WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.

**ICW1 is recognized in any state** when `wr & ~a0 & din[4]`. On ICW1:
- Load `ltim = din[3]`, `sngl = din[1]`, `ic4 = din[0]`.
- Clear `im` to 0x00, `operation` to 0, `aeoi` to 0, `read_isr` to 0.
- Abort any INTA sequence.
- Go to WAIT_ICW2.

**Init sequence writes:**
- WAIT_ICW2, on `wr & a0`: `vec_base = din[7:3]`. Next state is WAIT_ICW3 if `~sngl`, else WAIT_ICW4 if `ic4`, else READY.
- WAIT_ICW3, on `wr & a0`: store `icw3 = din` (held internally only). Next state is WAIT_ICW4 if `ic4`, else READY.
- WAIT_ICW4, on `wr & a0`: `aeoi = din[1]`. Next state is READY.
- In the WAIT states, writes with `a0 = 0` and `din[4] = 0` are ignored.

**READY-state writes:**
- `wr & a0` (OCW1): `im = din`.
- `wr & ~a0`, `din[4:3] = 00` (OCW2): `operation = din`, pulse `op_strobe`.
- `wr & ~a0`, `din[4:3] = 01` (OCW3): if `din[1]`, then `read_isr = din[0]`; otherwise no change.

**INTA sequencer:**
- Register `inta_n`. A falling edge is `inta_q & ~inta_n`.
- Edges are ignored unless `init_done`.
- 2-bit `ack_cnt`:
  - Edge with `ack_cnt == 0`: pulse `first_ack`, set `ack_cnt = 1`.
  - Edge with `ack_cnt == 1`: pulse `second_ack`, set `ack_cnt = 0`, set `vec_pending`.
- The cycle after `second_ack`: latch `vec_out = {vec_base, int_vec}` and set `vec_oe = 1`. `vec_oe` clears on the first cycle `inta_n == 1`.

**Reset values:** state WAIT_ICW1; `im` 0xFF; `ltim`, `aeoi`, `read_isr`, `ic4` 0; `sngl` 1; `operation` 0x00; `vec_base` 0; `ack_cnt` 0; `inta_q` 1; all pulses 0; `vec_out` 0x00; `vec_oe` 0; `init_done` 0.

## Timing
- A write sampled at edge N is visible on the outputs after edge N; `op_strobe` is high for exactly the cycle after edge N.
- `first_ack` and `second_ack` rise one cycle after the cycle in which `inta_n` is first sampled low; width is one cycle.
- `vec_out`/`vec_oe` are valid two cycles after the second falling edge of `inta_n` and remain valid until `inta_n` is sampled high.
- **Simultaneous events:**
  - An ICW1 write coinciding with an INTA edge: ICW1 wins and no ack pulse is issued.
  - An OCW write coinciding with an INTA edge: both take effect.
- **Reset:** `reset` mid-sequence returns all state to reset values at the next edge, regardless of `ack_cnt`.
- **INTA stuck low:** `inta_n` held low does not re-trigger; a new pulse requires `inta_n` to return high.

## Structure
- Package `pic_pkg`:
  - Init FSM state enum.
  - ICW1 flag position (bit 4) and OCW2/OCW3 select values (`din[4:3]`).
  - OCW2 command codes: non-specific EOI 3'b001, specific EOI 3'b011, rotating 2'b10/2'b11.
- Sub-module `inta_sequencer`: edge detect, `ack_cnt`, ack pulses and vector latch, with an abort input driven by ICW1.

## Test plan
- Reset → `im` = 0xFF, `init_done` = 0, `int_out` = 0 even with `int_req` = 1.
- ICW1 = 0x13 (single, IC4), ICW2 = 0x40, ICW4 = 0x02 → `init_done` = 1 after the third write, `aeoi` = 1, `im` = 0x00, WAIT_ICW3 skipped.
- After init: OCW1 = 0xF0 → `im` = 0xF0; OCW2 = 0x20 → `operation` = 0x20 with a one-cycle `op_strobe`; OCW3 = 0x0B → `read_isr` = 1.
- Two INTA low pulses with `int_vec` = 5 and `vec_base` = 0x08 (ICW2 = 0x40) → one `first_ack` pulse, one `second_ack` pulse, then `vec_out` = 0x45 with `vec_oe` held until `inta_n` rises.
- ICW1 written between the first and second INTA pulse → no `second_ack`; the next INTA after re-initialization produces `first_ack`.
- ICW1 = 0x10 (cascade, no IC4) → state sequence WAIT_ICW2 → WAIT_ICW3 → READY; `reset` asserted mid-init → WAIT_ICW1 with all outputs at reset values.
